// File: rtl/mem_access.sv
// mem_access: MEM stage that drives a req/ack data memory and holds the pipeline
// until the access completes; misaligned or trapped accesses become a 1-cycle trap.
module mem_access (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        PIP_write_mem_i,
  input  logic        PIP_read_mem_i,
  input  logic [31:0] PIP_alu_result_i,
  input  logic [31:0] PIP_second_operand_i,
  input  logic [1:0]  PIP_mem_size_i,
  input  logic        PIP_mem_unsigned_i,
  input  logic        PIP_use_mem_i,
  input  logic        PIP_write_reg_i,
  input  logic [4:0]  PIP_rd_i,
  input  logic        PIP_TRAP_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        stall_o,
  output logic [31:0] PIP_result_o,
  output logic [4:0]  PIP_rd_o,
  output logic        PIP_write_reg_o,
  output logic        PIP_TRAP_o
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t      r_state;
  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic        r_use_mem;
  logic        r_write_reg;
  logic [4:0]  r_rd;
  logic        w_mem;
  logic        w_aligned;
  logic        w_access;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  assign w_mem     = PIP_write_mem_i | PIP_read_mem_i;
  assign w_aligned = PIP_mem_size_i == 2'b00 ? 1'b1 :
                     PIP_mem_size_i == 2'b01 ? !PIP_alu_result_i[0] :
                     PIP_alu_result_i[1:0] == 2'b00;
  assign w_access  = w_mem & !PIP_TRAP_i & w_aligned;
  // BUSY ignores the (frozen) EX/MEM inputs and only waits for ack
  assign stall_o   = r_state == IDLE ? w_access : !dmem_ack_i;

  assign w_be    = PIP_mem_size_i == 2'b00 ? 4'b0001 << PIP_alu_result_i[1:0] :
                   PIP_mem_size_i == 2'b01 ? 4'b0011 << PIP_alu_result_i[1:0] : 4'b1111;
  assign w_wdata = PIP_mem_size_i == 2'b00 ? {4{PIP_second_operand_i[7:0]}} :
                   PIP_mem_size_i == 2'b01 ? {2{PIP_second_operand_i[15:0]}} : PIP_second_operand_i;

  assign w_byte = dmem_rdata_i[{r_addr[1:0], 3'b000} +: 8];
  assign w_half = r_addr[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
  assign w_load = r_size == 2'b00 ? {{24{!r_unsigned & w_byte[7]}}, w_byte} :
                  r_size == 2'b01 ? {{16{!r_unsigned & w_half[15]}}, w_half} : dmem_rdata_i;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state         <= IDLE;
      dmem_req_o      <= 1'b0;
      dmem_we_o       <= 1'b0;
      dmem_addr_o     <= '0;
      dmem_wdata_o    <= '0;
      dmem_be_o       <= '0;
      PIP_result_o    <= '0;
      PIP_rd_o        <= '0;
      PIP_write_reg_o <= 1'b0;
      PIP_TRAP_o      <= 1'b0;
      r_addr          <= '0;
      r_size          <= '0;
      r_unsigned      <= 1'b0;
      r_use_mem       <= 1'b0;
      r_write_reg     <= 1'b0;
      r_rd            <= '0;
    end else if (r_state == IDLE) begin
      if (w_access) begin
        r_state         <= BUSY;
        dmem_req_o      <= 1'b1;
        dmem_we_o       <= PIP_write_mem_i;
        dmem_addr_o     <= {PIP_alu_result_i[31:2], 2'b00};
        dmem_wdata_o    <= w_wdata;
        dmem_be_o       <= w_be;
        r_addr          <= PIP_alu_result_i;
        r_size          <= PIP_mem_size_i;
        r_unsigned      <= PIP_mem_unsigned_i;
        r_use_mem       <= PIP_use_mem_i;
        r_write_reg     <= PIP_write_reg_i & !PIP_write_mem_i;
        r_rd            <= PIP_rd_i;
        PIP_write_reg_o <= 1'b0;
        PIP_TRAP_o      <= 1'b0;
      end else begin
        // a memory op that is not an access was either trapped upstream or misaligned
        PIP_result_o    <= PIP_alu_result_i;
        PIP_rd_o        <= PIP_rd_i;
        PIP_write_reg_o <= PIP_write_reg_i & !w_mem & !PIP_TRAP_i;
        PIP_TRAP_o      <= PIP_TRAP_i | w_mem;
      end
    end else if (dmem_ack_i) begin
      r_state         <= IDLE;
      dmem_req_o      <= 1'b0;
      PIP_result_o    <= r_use_mem ? w_load : r_addr;
      PIP_rd_o        <= r_rd;
      PIP_write_reg_o <= r_write_reg;
      PIP_TRAP_o      <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: table vectors for single-cycle ops, hand sequences for the
// multi-cycle corners, and random traffic against a byte-level memory model.
module tb_mem_access;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        PIP_write_mem_i = 1'b0;
  logic        PIP_read_mem_i = 1'b0;
  logic [31:0] PIP_alu_result_i = '0;
  logic [31:0] PIP_second_operand_i = '0;
  logic [1:0]  PIP_mem_size_i = '0;
  logic        PIP_mem_unsigned_i = 1'b0;
  logic        PIP_use_mem_i = 1'b0;
  logic        PIP_write_reg_i = 1'b0;
  logic [4:0]  PIP_rd_i = '0;
  logic        PIP_TRAP_i = 1'b0;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_ack_i = 1'b0;
  logic [31:0] dmem_rdata_i = '0;
  logic        stall_o;
  logic [31:0] PIP_result_o;
  logic [4:0]  PIP_rd_o;
  logic        PIP_write_reg_o;
  logic        PIP_TRAP_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] ref_mem [0:15];

  mem_access dut (
    .clk(clk), .reset_n(reset_n),
    .PIP_write_mem_i(PIP_write_mem_i), .PIP_read_mem_i(PIP_read_mem_i),
    .PIP_alu_result_i(PIP_alu_result_i), .PIP_second_operand_i(PIP_second_operand_i),
    .PIP_mem_size_i(PIP_mem_size_i), .PIP_mem_unsigned_i(PIP_mem_unsigned_i),
    .PIP_use_mem_i(PIP_use_mem_i), .PIP_write_reg_i(PIP_write_reg_i),
    .PIP_rd_i(PIP_rd_i), .PIP_TRAP_i(PIP_TRAP_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
    .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
    .stall_o(stall_o), .PIP_result_o(PIP_result_o), .PIP_rd_o(PIP_rd_o),
    .PIP_write_reg_o(PIP_write_reg_o), .PIP_TRAP_o(PIP_TRAP_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wm;
    logic        rm;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        um;
    logic        wreg;
    logic [4:0]  rd;
    logic        trap;
    logic        e_wr;
    logic        e_trap;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic wm, input logic rm, input logic [31:0] addr, input logic [31:0] data,
                        input logic [1:0] size, input logic uns, input logic um, input logic wr,
                        input logic [4:0] rd, input logic tr);
    PIP_write_mem_i = wm; PIP_read_mem_i = rm; PIP_alu_result_i = addr;
    PIP_second_operand_i = data; PIP_mem_size_i = size; PIP_mem_unsigned_i = uns;
    PIP_use_mem_i = um; PIP_write_reg_i = wr; PIP_rd_i = rd; PIP_TRAP_i = tr;
  endtask

  task automatic apply_vec(input vec_t v);
    set_in(v.wm, v.rm, v.addr, 32'h0, v.size, 1'b0, v.um, v.wreg, v.rd, v.trap);
    @(negedge clk);
    chk("vec_stall", {31'b0, stall_o}, 32'h0);
    @(posedge clk); #1;
    chk("vec_req", {31'b0, dmem_req_o}, 32'h0);
    chk("vec_result", PIP_result_o, v.addr);
    chk("vec_rd", {27'b0, PIP_rd_o}, {27'b0, v.rd});
    chk("vec_wr", {31'b0, PIP_write_reg_o}, {31'b0, v.e_wr});
    chk("vec_trap", {31'b0, PIP_TRAP_o}, {31'b0, v.e_trap});
  endtask

  // Whole-transaction model: expectations derived from byte lanes of a word memory.
  task automatic do_op(input logic wm, input logic rm, input logic [31:0] addr, input logic [31:0] data,
                       input logic [1:0] size, input logic uns, input logic um, input logic wr,
                       input logic [4:0] rd, input logic tr, input int dly);
    int n, off;
    logic acc;
    logic [31:0] e_be, e_wd, w, v;
    set_in(wm, rm, addr, data, size, uns, um, wr, rd, tr);
    n = size == 2'd0 ? 1 : size == 2'd1 ? 2 : 4;
    off = int'(addr % 4);
    acc = (wm | rm) && !tr && (addr % n) == 0;
    e_be = ((32'd1 << n) - 32'd1) << off;
    for (int k = 0; k < 4; k++) e_wd[8*k +: 8] = data[8*(k % n) +: 8];
    w = ref_mem[addr[5:2]];
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = w[8*(off+i) +: 8];
    if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    @(negedge clk);
    chk("issue_stall", {31'b0, stall_o}, {31'b0, acc});
    @(posedge clk); #1;
    if (!acc) begin
      chk("pass_req", {31'b0, dmem_req_o}, 32'h0);
      chk("pass_result", PIP_result_o, addr);
      chk("pass_rd", {27'b0, PIP_rd_o}, {27'b0, rd});
      chk("pass_wr", {31'b0, PIP_write_reg_o}, {31'b0, wr && !(wm | rm) && !tr});
      chk("pass_trap", {31'b0, PIP_TRAP_o}, {31'b0, tr || wm || rm});
    end else begin
      chk("req_up", {31'b0, dmem_req_o}, 32'h1);
      chk("req_addr", dmem_addr_o, addr & 32'hFFFF_FFFC);
      chk("req_we", {31'b0, dmem_we_o}, {31'b0, wm});
      chk("bubble_wr", {31'b0, PIP_write_reg_o}, 32'h0);
      chk("bubble_trap", {31'b0, PIP_TRAP_o}, 32'h0);
      if (wm) begin
        chk("store_be", {28'b0, dmem_be_o}, e_be);
        chk("store_wdata", dmem_wdata_o, e_wd);
      end
      for (int i = 0; i < dly; i++) begin
        @(negedge clk);
        chk("busy_stall", {31'b0, stall_o}, 32'h1);
        @(posedge clk); #1;
        chk("busy_req", {31'b0, dmem_req_o}, 32'h1);
        chk("busy_addr", dmem_addr_o, addr & 32'hFFFF_FFFC);
        chk("busy_wr", {31'b0, PIP_write_reg_o}, 32'h0);
      end
      dmem_ack_i = 1'b1;
      dmem_rdata_i = wm ? $urandom : w;
      @(negedge clk);
      chk("ack_stall", {31'b0, stall_o}, 32'h0);
      @(posedge clk); #1;
      dmem_ack_i = 1'b0;
      dmem_rdata_i = $urandom;
      chk("done_req", {31'b0, dmem_req_o}, 32'h0);
      chk("done_wr", {31'b0, PIP_write_reg_o}, {31'b0, !wm && wr});
      chk("done_trap", {31'b0, PIP_TRAP_o}, 32'h0);
      chk("done_rd", {27'b0, PIP_rd_o}, {27'b0, rd});
      if (!wm) chk("load_result", PIP_result_o, um ? v : addr);
      if (wm) for (int k = 0; k < n; k++) ref_mem[addr[5:2]][8*(off+k) +: 8] = data[8*k +: 8];
    end
  endtask

  initial begin
    vec_t vecs [9];
    vecs[0] = '{1'b0, 1'b0, 32'h0000_1234, 2'd2, 1'b0, 1'b1, 5'd5,  1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 32'hDEAD_BEEF, 2'd0, 1'b0, 1'b0, 5'd31, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_0101, 2'd2, 1'b1, 1'b1, 5'd3,  1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0203, 2'd1, 1'b0, 1'b0, 5'd4,  1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 32'h0000_0007, 2'd1, 1'b1, 1'b1, 5'd6,  1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 32'h0000_0102, 2'd3, 1'b1, 1'b1, 5'd7,  1'b0, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 32'h0000_0100, 2'd2, 1'b1, 1'b1, 5'd8,  1'b1, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 32'h0000_5555, 2'd2, 1'b0, 1'b1, 5'd9,  1'b1, 1'b0, 1'b1};
    vecs[8] = '{1'b1, 1'b0, 32'h0000_0002, 2'd2, 1'b0, 1'b0, 5'd10, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 16; i++) ref_mem[i] = $urandom;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'b0, dmem_req_o}, 32'h0);
    chk("rst_we", {31'b0, dmem_we_o}, 32'h0);
    chk("rst_be", {28'b0, dmem_be_o}, 32'h0);
    chk("rst_addr", dmem_addr_o, 32'h0);
    chk("rst_wdata", dmem_wdata_o, 32'h0);
    chk("rst_result", PIP_result_o, 32'h0);
    chk("rst_rd", {27'b0, PIP_rd_o}, 32'h0);
    chk("rst_wr", {31'b0, PIP_write_reg_o}, 32'h0);
    chk("rst_trap", {31'b0, PIP_TRAP_o}, 32'h0);
    chk("rst_stall", {31'b0, stall_o}, 32'h0);
    reset_n = 1'b1;
    for (int i = 0; i < 9; i++) apply_vec(vecs[i]);
    ref_mem[0] = 32'h80FF_FF00;
    do_op(1'b0, 1'b1, 32'h0000_0103, 32'h0, 2'd0, 1'b0, 1'b1, 1'b1, 5'd11, 1'b0, 1);
    chk("lb_result", PIP_result_o, 32'hFFFF_FF80);
    chk("lb_addr", dmem_addr_o, 32'h0000_0100);
    do_op(1'b1, 1'b0, 32'h0000_0202, 32'hABCD_5678, 2'd1, 1'b0, 1'b0, 1'b1, 5'd12, 1'b0, 2);
    chk("sh_be", {28'b0, dmem_be_o}, 32'hC);
    chk("sh_wdata", dmem_wdata_o, 32'h5678_5678);
    ref_mem[0] = 32'h8001_0000;
    do_op(1'b0, 1'b1, 32'h0000_0002, 32'h0, 2'd1, 1'b1, 1'b1, 1'b1, 5'd13, 1'b0, 0);
    chk("lhu_result", PIP_result_o, 32'h0000_8001);
    do_op(1'b0, 1'b0, 32'h0000_4321, 32'h0, 2'd2, 1'b0, 1'b0, 1'b1, 5'd14, 1'b0, 0);
    do_op(1'b1, 1'b1, 32'h0000_0010, 32'h1122_3344, 2'd2, 1'b0, 1'b1, 1'b1, 5'd15, 1'b0, 1);
    set_in(1'b0, 1'b1, 32'h0000_0040, 32'h0, 2'd2, 1'b0, 1'b1, 1'b1, 5'd16, 1'b0);
    @(posedge clk); #1;
    chk("rbusy_req", {31'b0, dmem_req_o}, 32'h1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("rbusy_req_drop", {31'b0, dmem_req_o}, 32'h0);
    chk("rbusy_wr", {31'b0, PIP_write_reg_o}, 32'h0);
    dmem_ack_i = 1'b1;
    dmem_rdata_i = 32'hCAFE_F00D;
    @(negedge clk);
    chk("late_ack_stall", {31'b0, stall_o}, 32'h0);
    @(posedge clk); #1;
    dmem_ack_i = 1'b0;
    chk("late_ack_req", {31'b0, dmem_req_o}, 32'h0);
    chk("late_ack_wr", {31'b0, PIP_write_reg_o}, 32'h0);
    chk("late_ack_result", PIP_result_o, 32'h0);
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = $urandom;
      do_op($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, a, $urandom,
            2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom),
            5'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 3));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
